// File: rtl/register_bank.sv
// -----------------------------------------------------------------------------
// register_bank
//
// Architectural register set wrapped around the 16-bit ALU. AC drives BusA, a
// selectable source drives BusB, and the ALU result on BusC is written back
// into any combination of registers at the next rising edge. PC, AR and R1
// also have an in-place increment path, and the ALU Z flag can be latched for
// branch decisions. All sequencing comes from the control unit.
//
// Ports
//   Clock      in   1      rising-edge clock for all state
//   Reset      in   1      synchronous active-high clear of all registers/ZFlag
//   BusC       in   WIDTH  ALU result, load source for every register
//   FlagZ      in   1      ALU zero flag
//   MemDataIn  in   WIDTH  memory read data (DR load source, BusB select 6)
//   DRFromMem  in   1      DR load source: 1 = MemDataIn, 0 = BusC
//   LoadMask   in   7      load enables [0]AC [1]R1 [2]R2 [3]R3 [4]PC [5]AR [6]DR
//   IncMask    in   3      increment enables [0]PC [1]AR [2]R1
//   ZLoad      in   1      capture FlagZ into ZFlag
//   BusBSel    in   3      BusB source: 0 DR 1 R1 2 R2 3 R3 4 PC 5 AR 6 Mem 7 zero
//   BusA       out  WIDTH  AC
//   BusB       out  WIDTH  selected source
//   PCOut      out  WIDTH  current PC
//   AROut      out  WIDTH  current AR
//   ZFlag      out  1      registered zero flag
// -----------------------------------------------------------------------------
module register_bank #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] BusC,
    input  logic             FlagZ,
    input  logic [WIDTH-1:0] MemDataIn,
    input  logic             DRFromMem,
    input  logic [6:0]       LoadMask,
    input  logic [2:0]       IncMask,
    input  logic             ZLoad,
    input  logic [2:0]       BusBSel,
    output logic [WIDTH-1:0] BusA,
    output logic [WIDTH-1:0] BusB,
    output logic [WIDTH-1:0] PCOut,
    output logic [WIDTH-1:0] AROut,
    output logic             ZFlag
);

    // LoadMask bit positions
    localparam int LdAc = 0;
    localparam int LdR1 = 1;
    localparam int LdR2 = 2;
    localparam int LdR3 = 3;
    localparam int LdPc = 4;
    localparam int LdAr = 5;
    localparam int LdDr = 6;

    // IncMask bit positions
    localparam int IncPc = 0;
    localparam int IncAr = 1;
    localparam int IncR1 = 2;

    // BusB source encodings
    typedef enum logic [2:0] {
        SelDr   = 3'd0,
        SelR1   = 3'd1,
        SelR2   = 3'd2,
        SelR3   = 3'd3,
        SelPc   = 3'd4,
        SelAr   = 3'd5,
        SelMem  = 3'd6,
        SelZero = 3'd7
    } busBSrc_t;

    logic [WIDTH-1:0] acReg;
    logic [WIDTH-1:0] r1Reg;
    logic [WIDTH-1:0] r2Reg;
    logic [WIDTH-1:0] r3Reg;
    logic [WIDTH-1:0] pcReg;
    logic [WIDTH-1:0] arReg;
    logic [WIDTH-1:0] drReg;
    logic             zReg;

    logic [WIDTH-1:0] drLoadValue;
    assign drLoadValue = DRFromMem ? MemDataIn : BusC;

    // Each register follows the same priority: reset, load, increment, hold.
    // Increments wrap naturally because the sum is truncated to WIDTH bits.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            acReg <= '0;
            r1Reg <= '0;
            r2Reg <= '0;
            r3Reg <= '0;
            pcReg <= '0;
            arReg <= '0;
            drReg <= '0;
            zReg  <= 1'b0;
        end else begin
            if (LoadMask[LdAc]) acReg <= BusC;

            if (LoadMask[LdR1])      r1Reg <= BusC;
            else if (IncMask[IncR1]) r1Reg <= r1Reg + WIDTH'(1);

            if (LoadMask[LdR2]) r2Reg <= BusC;
            if (LoadMask[LdR3]) r3Reg <= BusC;

            if (LoadMask[LdPc])      pcReg <= BusC;
            else if (IncMask[IncPc]) pcReg <= pcReg + WIDTH'(1);

            if (LoadMask[LdAr])      arReg <= BusC;
            else if (IncMask[IncAr]) arReg <= arReg + WIDTH'(1);

            if (LoadMask[LdDr]) drReg <= drLoadValue;

            if (ZLoad) zReg <= FlagZ;
        end
    end

    // BusB source mux. Select 6 is the only combinational input-to-output path.
    // NOTE: BusB gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        BusB = '0;
        unique case (busBSrc_t'(BusBSel))
            SelDr:   BusB = drReg;
            SelR1:   BusB = r1Reg;
            SelR2:   BusB = r2Reg;
            SelR3:   BusB = r3Reg;
            SelPc:   BusB = pcReg;
            SelAr:   BusB = arReg;
            SelMem:  BusB = MemDataIn;
            SelZero: BusB = '0;
            default: BusB = '0;
        endcase
    end

    assign BusA  = acReg;
    assign PCOut = pcReg;
    assign AROut = arReg;
    assign ZFlag = zReg;

endmodule
